// File: rtl/brc_iter_if.sv
// Request/result handshake bundle for the iterative branch comparator.
// Member names match the original flat port list so existing hookups map 1:1.
interface brc_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic [2:0]       i_funct3;
    logic             o_valid;
    logic             i_ready;
    logic             o_brc_less;
    logic             o_brc_equal;
    logic             o_br_taken;
    logic             o_br_illegal;

    // Requester side: register-read stage issuing operands, PC-select consuming results.
    modport master (
        output i_valid, i_rs1_data, i_rs2_data, i_funct3, i_ready,
        input  o_ready, o_valid, o_brc_less, o_brc_equal, o_br_taken, o_br_illegal
    );

    // Comparator side.
    modport slave (
        input  i_valid, i_rs1_data, i_rs2_data, i_funct3, i_ready,
        output o_ready, o_valid, o_brc_less, o_brc_equal, o_br_taken, o_br_illegal
    );
endinterface

// File: rtl/brc_iter.sv
// Multi-cycle branch comparator: scans operands MSB-first, DIGIT bits per
// cycle, exits on the first differing digit and decodes funct3 into taken.
module brc_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input logic   i_clk,
    input logic   i_reset,
    brc_iter_if.slave bus
);
    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("brc_iter: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       funct3_q;
    logic [CNT_W-1:0] cnt;
    logic             less_q, equal_q, taken_q, illegal_q;

    logic [DIGIT-1:0] digit_a, digit_b;
    logic             digit_differ, digit_less, last_step, accept, op_unsigned;

    // Only BLTU/BGEU compare unsigned; everything else (illegal codes too) is signed.
    function automatic logic decode_taken(input logic [2:0] f3, input logic less,
                                          input logic equal);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:         t = equal;
            3'b001:         t = !equal;
            3'b100, 3'b110: t = less;
            3'b101, 3'b111: t = !less;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    // Current digit pair and scan-progress flags.
    always_comb begin
        digit_a      = a_sh[WIDTH-1 -: DIGIT];
        digit_b      = b_sh[WIDTH-1 -: DIGIT];
        digit_differ = (digit_a != digit_b);
        digit_less   = (digit_a < digit_b);
        last_step    = (cnt == CNT_W'(STEPS - 1));
        accept       = bus.i_valid && (state_q == IDLE);
        op_unsigned  = bus.i_funct3[2] && bus.i_funct3[1];
    end

    // State register; reset drops any in-flight request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (digit_differ || last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, digit shifting and result registers.
    // Flipping the MSB maps signed order onto unsigned order, so the scan
    // only ever needs an unsigned digit compare; equality is unaffected.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            funct3_q  <= '0;
            cnt       <= '0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh     <= op_unsigned ? bus.i_rs1_data : (bus.i_rs1_data ^ MSB_MASK);
                        b_sh     <= op_unsigned ? bus.i_rs2_data : (bus.i_rs2_data ^ MSB_MASK);
                        funct3_q <= bus.i_funct3;
                        cnt      <= '0;
                    end
                end
                SCAN: begin
                    if (digit_differ) begin
                        less_q    <= digit_less;
                        equal_q   <= 1'b0;
                        taken_q   <= decode_taken(funct3_q, digit_less, 1'b0);
                        illegal_q <= (funct3_q[2:1] == 2'b01);
                    end else if (last_step) begin
                        less_q    <= 1'b0;
                        equal_q   <= 1'b1;
                        taken_q   <= decode_taken(funct3_q, 1'b0, 1'b1);
                        illegal_q <= (funct3_q[2:1] == 2'b01);
                    end else begin
                        a_sh <= a_sh << DIGIT;
                        b_sh <= b_sh << DIGIT;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_brc_less   = less_q;
    assign bus.o_brc_equal  = equal_q;
    assign bus.o_br_taken   = taken_q;
    assign bus.o_br_illegal = illegal_q;
endmodule

// File: tb/tb_brc_iter.sv
// Directed bench for brc_iter (WIDTH=32, DIGIT=8) with hand-computed expectations.
module tb_brc_iter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    brc_iter_if #(.WIDTH(32)) bus ();

    brc_iter #(.WIDTH(32), .DIGIT(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic e_less, input logic e_eq,
                                 input logic e_taken, input logic e_ill);
        check({tag, ".less"},    bus.o_brc_less,   e_less);
        check({tag, ".equal"},   bus.o_brc_equal,  e_eq);
        check({tag, ".taken"},   bus.o_br_taken,   e_taken);
        check({tag, ".illegal"}, bus.o_br_illegal, e_ill);
    endtask

    // Issue one request, measure accept-to-valid latency, optionally hold
    // backpressure for `hold` cycles (with a stray i_valid pulse), then retire.
    task automatic run_req(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic e_less,
                           input logic e_eq, input logic e_taken, input logic e_ill,
                           input int hold);
        int lat;
        bus.i_valid    = 1'b1;
        bus.i_funct3   = f3;
        bus.i_rs1_data = a;
        bus.i_rs2_data = b;
        bus.i_ready    = 1'b0;
        check({tag, ".ready_idle"}, bus.o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; they must have no effect.
        bus.i_valid    = 1'b0;
        bus.i_funct3   = ~f3;
        bus.i_rs1_data = a ^ 32'hDEADBEEF;
        bus.i_rs2_data = b ^ 32'h0BADF00D;
        check({tag, ".ready_scan"}, bus.o_ready, 1'b0);
        lat = 1;
        while (!bus.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.o_valid) begin
            check({tag, ".timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check_results(tag, e_less, e_eq, e_taken, e_ill);
        for (int h = 0; h < hold; h++) begin
            check({tag, ".hold_valid"}, bus.o_valid, 1'b1);
            check({tag, ".hold_ready"}, bus.o_ready, 1'b0);
            check_results({tag, ".hold"}, e_less, e_eq, e_taken, e_ill);
            bus.i_valid    = (h == 1);
            bus.i_rs1_data = 32'h0;
            bus.i_rs2_data = 32'h0;
            bus.i_funct3   = 3'b000;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({tag, ".valid_drop"}, bus.o_valid, 1'b0);
        check({tag, ".ready_back"}, bus.o_ready, 1'b1);
        check_results({tag, ".retained"}, e_less, e_eq, e_taken, e_ill);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b0;
        bus.i_funct3   = 3'b000;
        bus.i_rs1_data = 32'h0;
        bus.i_rs2_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst.ready", bus.o_ready, 1'b1);
        check("rst.valid", bus.o_valid, 1'b0);
        check_results("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // tag, f3, A, B, latency, less, equal, taken, illegal, hold
        run_req("beq_eq",  3'b000, 32'h12345678, 32'h12345678, 5, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run_req("blt",     3'b100, 32'hFFFFFFFF, 32'h00000001, 2, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_req("bltu",    3'b110, 32'hFFFFFFFF, 32'h00000001, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_req("bgeu",    3'b111, 32'h000000FF, 32'h00000100, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_req("bge",     3'b101, 32'h80000000, 32'h7FFFFFFF, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_req("bne_bp",  3'b001, 32'h00000001, 32'h00000002, 5, 1'b1, 1'b0, 1'b1, 1'b0, 5);

        // The i_valid pulse during the hold must not have been queued.
        repeat (3) @(negedge clk);
        check("bp.no_queue", bus.o_valid, 1'b0);

        // Reset in the second SCAN cycle drops the request and clears outputs.
        bus.i_valid    = 1'b1;
        bus.i_funct3   = 3'b000;
        bus.i_rs1_data = 32'h00000001;
        bus.i_rs2_data = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.valid", bus.o_valid, 1'b0);
        check("midrst.ready", bus.o_ready, 1'b1);
        check_results("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("midrst.no_result", bus.o_valid, 1'b0);

        run_req("ill_010", 3'b010, 32'h00000000, 32'h00000000, 5, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        run_req("ill_011", 3'b011, 32'hFFFFFFFF, 32'h00000001, 2, 1'b1, 1'b0, 1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
